// File: rtl/menu_sequencer.sv
// Menu page sequencer: loads menu defaults, walks menu_sel through the pages of the
// selected mode, handles confirm/back navigation and aborts to idle on inactivity.
//
// state      | meaning
// IDLE       | waiting for start, menu inactive
// LOAD       | one-cycle pulse of load_initial
// SEL_MODO   | choosing the mode (page 0)
// SEL_BPM    | editing bpm (page 1)
// SEL_TOM    | editing tom (page 2)
// SEL_MUSICA | choosing song (page 3)
// SEL_ERRO   | editing error tolerance (page 4)
// SEL_GRAVA  | record settings (page 5)
// DONE       | configuration complete and held
module menu_sequencer #(
    parameter int MODO    = 4,
    parameter int TIMEOUT = 500000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            confirm_pressed,
    input  logic            back_pressed,
    input  logic            arrow_activity,
    input  logic [MODO-1:0] modos,
    output logic [2:0]      menu_sel,
    output logic            load_initial,
    output logic            menu_active,
    output logic            config_valid,
    output logic            config_done,
    output logic            timeout,
    output logic [3:0]      db_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD       = 4'd1,
        SEL_MODO   = 4'd2,
        SEL_BPM    = 4'd3,
        SEL_TOM    = 4'd4,
        SEL_MUSICA = 4'd5,
        SEL_ERRO   = 4'd6,
        SEL_GRAVA  = 4'd7,
        DONE       = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        PATH_FREE   = 2'd0,
        PATH_LEARN  = 2'd1,
        PATH_RECORD = 2'd2,
        PATH_PLAY   = 2'd3
    } path_t;

    state_t          state, state_next;
    path_t           path, path_next;
    logic            prev_confirm, prev_back;
    logic [CW-1:0]   cnt;
    logic            cf, bk_raw, bk, activity, one_hot, abort;

    function automatic logic is_sel(input state_t s);
        return (s >= SEL_MODO) && (s <= SEL_GRAVA);
    endfunction

    // Button edge detection and activity qualification; confirm beats back.
    always_comb begin
        cf       = confirm_pressed & ~prev_confirm;
        bk_raw   = back_pressed & ~prev_back;
        bk       = bk_raw & ~cf;
        activity = cf | bk_raw | arrow_activity;
        one_hot  = (modos != '0) && ((modos & (modos - 1'b1)) == '0);
    end

    // Next-state logic: page navigation along the latched path, plus inactivity abort.
    always_comb begin
        state_next = state;
        path_next  = path;
        abort      = 1'b0;
        case (state)
            IDLE:     if (start) state_next = LOAD;
            LOAD:     state_next = SEL_MODO;
            DONE:     if (start) state_next = SEL_MODO;
            SEL_MODO: begin
                if (cf && one_hot) begin
                    if (modos[0])      path_next = PATH_FREE;
                    else if (modos[1]) path_next = PATH_LEARN;
                    else if (modos[2]) path_next = PATH_RECORD;
                    else               path_next = PATH_PLAY;
                    state_next = modos[3] ? SEL_MUSICA : SEL_BPM;
                end
            end
            SEL_BPM: begin
                if (cf)      state_next = SEL_TOM;
                else if (bk) state_next = SEL_MODO;
            end
            SEL_TOM: begin
                if (cf) begin
                    case (path)
                        PATH_LEARN:  state_next = SEL_MUSICA;
                        PATH_RECORD: state_next = SEL_GRAVA;
                        default:     state_next = DONE;
                    endcase
                end else if (bk) begin
                    state_next = SEL_BPM;
                end
            end
            SEL_MUSICA: begin
                if (cf)      state_next = (path == PATH_LEARN) ? SEL_ERRO : DONE;
                else if (bk) state_next = (path == PATH_LEARN) ? SEL_TOM : SEL_MODO;
            end
            SEL_ERRO: begin
                if (cf)      state_next = DONE;
                else if (bk) state_next = SEL_MUSICA;
            end
            SEL_GRAVA: begin
                if (cf)      state_next = DONE;
                else if (bk) state_next = SEL_TOM;
            end
            default:  state_next = IDLE;
        endcase
        // Any activity in the terminal cycle keeps the menu alive.
        if (is_sel(state) && (cnt == CNT_LAST) && !activity) begin
            state_next = IDLE;
            path_next  = path;
            abort      = 1'b1;
        end
    end

    // State, latched path and button history; history resets high so held buttons give no edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            path         <= PATH_FREE;
            prev_confirm <= 1'b1;
            prev_back    <= 1'b1;
        end else begin
            state        <= state_next;
            path         <= path_next;
            prev_confirm <= confirm_pressed;
            prev_back    <= back_pressed;
        end
    end

    // Inactivity counter: runs only while staying on a page with no activity.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (!is_sel(state_next) || (state_next != state) || activity) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Status flags: valid configuration, done pulse and timeout pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            config_valid <= 1'b0;
            config_done  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            config_done <= (state_next == DONE) && (state != DONE);
            timeout     <= abort;
            if (abort || ((state_next == LOAD) && (state != LOAD)))
                config_valid <= 1'b0;
            else if ((state_next == DONE) && (state != DONE))
                config_valid <= 1'b1;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        menu_sel     = 3'd0;
        load_initial = (state == LOAD);
        menu_active  = is_sel(state);
        db_state     = state;
        case (state)
            SEL_BPM:    menu_sel = 3'd1;
            SEL_TOM:    menu_sel = 3'd2;
            SEL_MUSICA: menu_sel = 3'd3;
            SEL_ERRO:   menu_sel = 3'd4;
            SEL_GRAVA:  menu_sel = 3'd5;
            default:    menu_sel = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_menu_sequencer.sv
// Bench for menu_sequencer: fixed vector table, hand-written timeout/reset sequences and
// random stimulus, all checked against a page-list reference model.
module tb_menu_sequencer;

    localparam int TIMEOUT = 20;

    logic       clock = 1'b0;
    logic       reset, start, confirm_pressed, back_pressed, arrow_activity;
    logic [3:0] modos;
    logic [2:0] menu_sel;
    logic       load_initial, menu_active, config_valid, config_done, timeout;
    logic [3:0] db_state;

    int n_vec = 0;
    int n_mis = 0;

    menu_sequencer #(.MODO(4), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .start(start),
        .confirm_pressed(confirm_pressed), .back_pressed(back_pressed),
        .arrow_activity(arrow_activity), .modos(modos),
        .menu_sel(menu_sel), .load_initial(load_initial), .menu_active(menu_active),
        .config_valid(config_valid), .config_done(config_done), .timeout(timeout),
        .db_state(db_state)
    );

    always #5 clock = ~clock;

    // Reference model: phase, path as a list of page codes, position in that list.
    int  paths[4][6];
    int  plen[4];
    int  m_phase = 0;   // 0 idle, 1 load, 2 editing, 3 done
    int  m_path  = 0;
    int  m_pos   = 0;
    int  m_cnt   = 0;
    bit  m_valid = 0, m_done = 0, m_to = 0, m_pc = 1, m_pb = 1;

    function automatic logic [11:0] pack(input int sel, input bit li, input bit act,
                                         input bit v, input bit d, input bit t, input int db);
        return {sel[2:0], li, act, v, d, t, db[3:0]};
    endfunction

    function automatic void model_step();
        bit cf, bkr, bk, act;
        int old_phase, old_pos;
        cf  = confirm_pressed && !m_pc;
        bkr = back_pressed && !m_pb;
        bk  = bkr && !cf;
        act = cf || bkr || arrow_activity;
        m_done = 0;
        m_to   = 0;
        if (reset) begin
            m_phase = 0; m_pos = 0; m_cnt = 0; m_valid = 0; m_pc = 1; m_pb = 1;
            return;
        end
        m_pc = confirm_pressed;
        m_pb = back_pressed;
        old_phase = m_phase;
        old_pos   = m_pos;
        case (m_phase)
            0: if (start) begin m_phase = 1; m_valid = 0; end
            1: begin m_phase = 2; m_pos = 0; end
            3: if (start) begin m_phase = 2; m_pos = 0; end
            default: begin
                if (m_cnt == TIMEOUT - 1 && !act) begin
                    m_phase = 0; m_valid = 0; m_to = 1;
                end else if (cf) begin
                    if (m_pos == 0) begin
                        if ($countones(modos) == 1) begin
                            for (int b = 0; b < 4; b++) if (modos[b]) m_path = b;
                            m_pos = 1;
                        end
                    end else begin
                        m_pos++;
                        if (m_pos == plen[m_path]) begin
                            m_phase = 3; m_valid = 1; m_done = 1;
                        end
                    end
                end else if (bk && m_pos > 0) begin
                    m_pos--;
                end
            end
        endcase
        if (m_phase == 2 && old_phase == 2 && m_pos == old_pos && !act) m_cnt++;
        else m_cnt = 0;
    endfunction

    function automatic logic [11:0] model_exp();
        int sel, db;
        sel = (m_phase == 2) ? paths[m_path][m_pos] : 0;
        case (m_phase)
            0:       db = 0;
            1:       db = 1;
            3:       db = 8;
            default: db = sel + 2;
        endcase
        return pack(sel, m_phase == 1, m_phase == 2, m_valid, m_done, m_to, db);
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = {menu_sel, load_initial, menu_active, config_valid, config_done, timeout, db_state};
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got sel=%0d li=%b act=%b val=%b done=%b to=%b db=%0d, expected sel=%0d li=%b act=%b val=%b done=%b to=%b db=%0d",
                     name, got[11:9], got[8], got[7], got[6], got[5], got[4], got[3:0],
                     exp[11:9], exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check(tag, model_exp());
    endtask

    typedef struct {
        bit          rst, st, cf, bk, ar;
        logic [3:0]  md;
        logic [11:0] exp;
    } vec_t;

    vec_t tab[$];

    task automatic add(input bit rst, input bit st, input bit cf, input bit bk,
                       input logic [3:0] md, input logic [11:0] exp);
        vec_t v;
        v.rst = rst; v.st = st; v.cf = cf; v.bk = bk; v.ar = 1'b0; v.md = md; v.exp = exp;
        tab.push_back(v);
    endtask

    initial begin
        paths = '{'{0, 1, 2, 0, 0, 0}, '{0, 1, 2, 3, 4, 0}, '{0, 1, 2, 5, 0, 0}, '{0, 3, 0, 0, 0, 0}};
        plen  = '{3, 5, 4, 2};

        reset = 1; start = 0; confirm_pressed = 0; back_pressed = 0; arrow_activity = 0;
        modos = 4'b0001;

        //   rst st cf bk modos           sel li act v d t db
        add(1, 0, 0, 0, 4'b0001, pack(0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0, 4'b0001, pack(0, 1, 0, 0, 0, 0, 1));
        add(0, 0, 0, 0, 4'b0001, pack(0, 0, 1, 0, 0, 0, 2));
        // learn path
        add(0, 0, 1, 0, 4'b0010, pack(1, 0, 1, 0, 0, 0, 3));
        add(0, 0, 0, 0, 4'b0010, pack(1, 0, 1, 0, 0, 0, 3));
        add(0, 0, 1, 0, 4'b0010, pack(2, 0, 1, 0, 0, 0, 4));
        add(0, 0, 0, 0, 4'b0010, pack(2, 0, 1, 0, 0, 0, 4));
        add(0, 0, 1, 0, 4'b0010, pack(3, 0, 1, 0, 0, 0, 5));
        add(0, 0, 0, 0, 4'b0010, pack(3, 0, 1, 0, 0, 0, 5));
        add(0, 0, 1, 0, 4'b0010, pack(4, 0, 1, 0, 0, 0, 6));
        add(0, 0, 0, 0, 4'b0010, pack(4, 0, 1, 0, 0, 0, 6));
        add(0, 0, 1, 0, 4'b0010, pack(0, 0, 0, 1, 1, 0, 8));
        add(0, 0, 0, 0, 4'b0010, pack(0, 0, 0, 1, 0, 0, 8));
        add(0, 0, 0, 0, 4'b0010, pack(0, 0, 0, 1, 0, 0, 8));
        // playback re-edit from DONE, back navigation, confirm beats back
        add(0, 1, 0, 0, 4'b1000, pack(0, 0, 1, 1, 0, 0, 2));
        add(0, 0, 1, 0, 4'b1000, pack(3, 0, 1, 1, 0, 0, 5));
        add(0, 0, 0, 1, 4'b1000, pack(0, 0, 1, 1, 0, 0, 2));
        add(0, 0, 0, 0, 4'b1000, pack(0, 0, 1, 1, 0, 0, 2));
        add(0, 0, 0, 1, 4'b1000, pack(0, 0, 1, 1, 0, 0, 2));
        add(0, 0, 0, 0, 4'b1000, pack(0, 0, 1, 1, 0, 0, 2));
        add(0, 0, 1, 1, 4'b1000, pack(3, 0, 1, 1, 0, 0, 5));
        add(0, 0, 0, 0, 4'b1000, pack(3, 0, 1, 1, 0, 0, 5));
        add(0, 0, 1, 0, 4'b1000, pack(0, 0, 0, 1, 1, 0, 8));
        add(0, 0, 0, 0, 4'b1000, pack(0, 0, 0, 1, 0, 0, 8));
        // multi-hot ignored, then record path
        add(1, 0, 0, 0, 4'b0011, pack(0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0, 4'b0011, pack(0, 1, 0, 0, 0, 0, 1));
        add(0, 0, 0, 0, 4'b0011, pack(0, 0, 1, 0, 0, 0, 2));
        add(0, 0, 1, 0, 4'b0011, pack(0, 0, 1, 0, 0, 0, 2));
        add(0, 0, 0, 0, 4'b0100, pack(0, 0, 1, 0, 0, 0, 2));
        add(0, 0, 1, 0, 4'b0100, pack(1, 0, 1, 0, 0, 0, 3));
        add(0, 0, 0, 0, 4'b0100, pack(1, 0, 1, 0, 0, 0, 3));
        add(0, 0, 1, 0, 4'b0100, pack(2, 0, 1, 0, 0, 0, 4));
        add(0, 0, 0, 0, 4'b0100, pack(2, 0, 1, 0, 0, 0, 4));
        add(0, 0, 1, 0, 4'b0100, pack(5, 0, 1, 0, 0, 0, 7));
        add(0, 0, 0, 0, 4'b0100, pack(5, 0, 1, 0, 0, 0, 7));
        add(0, 0, 1, 0, 4'b0100, pack(0, 0, 0, 1, 1, 0, 8));
        add(0, 0, 0, 0, 4'b0100, pack(0, 0, 0, 1, 0, 0, 8));

        foreach (tab[i]) begin
            reset = tab[i].rst; start = tab[i].st; confirm_pressed = tab[i].cf;
            back_pressed = tab[i].bk; arrow_activity = tab[i].ar; modos = tab[i].md;
            tick("model_table");
            check($sformatf("table[%0d]", i), tab[i].exp);
        end

        // Inactivity abort from SEL_BPM with a held configuration.
        start = 1; tick("to_start");
        start = 0; modos = 4'b0001; confirm_pressed = 1; tick("to_enter_bpm");
        confirm_pressed = 0;
        repeat (19) tick("to_wait");
        check("to_before_abort", pack(1, 0, 1, 1, 0, 0, 3));
        tick("to_abort_model");
        check("to_abort", pack(0, 0, 0, 0, 0, 1, 0));
        tick("to_pulse_model");
        check("to_pulse_end", pack(0, 0, 0, 0, 0, 0, 0));

        // Arrow activity in the terminal cycle prevents the abort.
        start = 1; tick("ar_load");
        start = 0; tick("ar_modo");
        confirm_pressed = 1; tick("ar_bpm");
        confirm_pressed = 0;
        repeat (19) tick("ar_wait");
        arrow_activity = 1; tick("ar_tc_model");
        check("arrow_at_tc", pack(1, 0, 1, 0, 0, 0, 3));
        arrow_activity = 0;
        repeat (19) tick("ar_wait2");
        check("arrow_restart", pack(1, 0, 1, 0, 0, 0, 3));
        tick("ar_abort_model");
        check("arrow_abort", pack(0, 0, 0, 0, 0, 1, 0));

        // Confirm held through reset, then reset while in SEL_TOM.
        confirm_pressed = 1;
        start = 1; tick("hold_load");
        start = 0; tick("hold_modo");
        reset = 1; tick("hold_rst_model");
        check("rst_hold", pack(0, 0, 0, 0, 0, 0, 0));
        reset = 0; start = 1; tick("hold_load2");
        start = 0; tick("hold_modo2");
        tick("hold_wait");
        tick("hold_wait");
        check("held_no_advance", pack(0, 0, 1, 0, 0, 0, 2));
        confirm_pressed = 0; tick("tom_rel");
        confirm_pressed = 1; tick("tom_bpm");
        confirm_pressed = 0; tick("tom_rel2");
        confirm_pressed = 1; tick("tom_tom");
        check("in_tom", pack(2, 0, 1, 0, 0, 0, 4));
        confirm_pressed = 0; reset = 1; tick("tom_rst_model");
        check("rst_in_tom", pack(0, 0, 0, 0, 0, 0, 0));
        reset = 0;

        // Random stimulus against the reference model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) confirm_pressed = ~confirm_pressed;
            if ($urandom_range(0, 3) == 0) back_pressed = ~back_pressed;
            arrow_activity = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1:    modos = 4'b0001;
                    2, 3:    modos = 4'b0010;
                    4, 5:    modos = 4'b0100;
                    6, 7:    modos = 4'b1000;
                    8:       modos = 4'b0000;
                    default: modos = 4'b0110;
                endcase
            end
            // Occasionally go quiet long enough to reach the terminal count.
            if ($urandom_range(0, 99) == 0) begin
                confirm_pressed = 0; back_pressed = 0; start = 0; reset = 0; arrow_activity = 0;
                repeat (TIMEOUT + 2) tick("random_quiet");
            end else begin
                tick("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
